// File: rtl/if_prefetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package  : riscv_pipe_pkg
// Brief    : Shared widths, fetch FSM encoding and FIFO entry layout.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_prefetch_queue_if.sv
`default_nettype none
// ============================================================================
// Interface : if_prefetch_queue_if
// Brief     : Redirect, instruction-memory and IF/ID-side signals of the fetch queue.
// Revision  : 1.0 - initial release
// ============================================================================
interface if_prefetch_queue_if #(
    parameter int DEPTH = 4
) ();
    import riscv_pipe_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
    logic            out_ready;
    logic [CW-1:0]   occupancy;

    // master is the fetch unit; slave is memory, MEM stage and IF/ID together
    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
               imem_resp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, occupancy
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
               imem_resp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, occupancy
    );

endinterface
`default_nettype wire

// File: rtl/if_prefetch_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : DEPTH-entry FIFO with synchronous push/pop/flush and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              flush,
    input  wire              push,
    input  wire  [WIDTH-1:0] push_data,
    input  wire              pop,
    output logic [WIDTH-1:0] head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            // Storage is left alone; only the pointers matter after a flush
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Credit accounting upstream must make these unreachable
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && (count_q == CW'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && !flush && (count_q == '0)));

endmodule
`default_nettype wire

// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_queue
// Brief    : Single-outstanding sequential fetcher feeding IF/ID through a small FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_queue
    import riscv_pipe_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input wire                  clk,
    input wire                  reset,
    if_prefetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [CW-1:0]   count;
    logic [CW-1:0]   free;
    logic            outstanding;
    logic            req_valid;
    logic            req_fire;
    logic            resp_push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign outstanding = (state_q != REQ);
    assign free        = CW'(DEPTH) - count - CW'(outstanding);

    // Gated by reset so the request drops the instant reset is asserted
    assign req_valid = (state_q == REQ) && (free != '0) && !bus.redirect_valid && !reset;
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign resp_push = (state_q == WAIT) && bus.imem_resp_valid && !bus.redirect_valid;
    assign pop       = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (req_fire) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 64'd4;
        end
        case (state_q)
            REQ:     if (req_fire) state_d = WAIT;
            WAIT:    if (bus.imem_resp_valid) state_d = REQ;
            DROP:    if (bus.imem_resp_valid) state_d = REQ;
            default: state_d = REQ;
        endcase
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc & ~64'h3;
            // Anything in flight at the redirect belongs to the wrong path
            if (state_q == WAIT || state_q == DROP) begin
                state_d = bus.imem_resp_valid ? REQ : DROP;
            end else begin
                state_d = req_fire ? DROP : REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    assign push_entry.pc    = req_pc_q;
    assign push_entry.instr = bus.imem_resp_data;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .push      (resp_push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (count)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.out_valid      = (count != '0);
    assign bus.out_pc         = head_entry.pc;
    assign bus.out_instr      = head_entry.instr;
    assign bus.occupancy      = count;

endmodule
`default_nettype wire
